// File: rtl/majority_pkg.sv
// Shared types and defaults for the majority-vote front end (collector and majority_circuit).
package majority_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } collect_state_t;

  localparam int MAJ_WIDTH_DEFAULT = 5;
  localparam int MAJ_DIV_DEFAULT   = 4;
  localparam int OVR_CNT_W         = 8;

endpackage

// File: rtl/sample_tick_gen.sv
// Prescaler for the sample collector: pulses tick once every DIV enabled clocks.
module sample_tick_gen
  import majority_pkg::*;
#(
  parameter int DIV = MAJ_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] psc;
  logic          wrap;

  assign wrap = (psc == PW'(DIV - 1));
  assign tick = en && wrap;

  // Dropping en restarts the sample period so a re-enable is phase-aligned again.
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      psc <= '0;
    end else if (wrap) begin
      psc <= '0;
    end else begin
      psc <= psc + 1'b1;
    end
  end

endmodule

// File: rtl/majority_sample_collector.sv
// Samples in_bit every DIV clocks, packs WIDTH_IN samples into a window, offers it on valid/ready.
// Optional drop counter ovr_cnt is built when OVERRUN_CNT_EN is defined.
module majority_sample_collector
  import majority_pkg::*;
#(
  parameter int WIDTH_IN = MAJ_WIDTH_DEFAULT,
  parameter int DIV      = MAJ_DIV_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                in_bit,
  input  logic                clr_ovr,
  output logic [WIDTH_IN-1:0] out_seq,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                overrun
`ifdef OVERRUN_CNT_EN
  ,
  output logic [OVR_CNT_W-1:0] ovr_cnt
`endif
);

  localparam int BW = $clog2(WIDTH_IN);

  collect_state_t state_q, state_d;

  logic                collecting;
  logic                tick;
  logic [WIDTH_IN-2:0] shreg;
  logic [BW-1:0]       bcnt;
  logic [WIDTH_IN-1:0] window;
  logic                done;
  logic                slot_free;
  logic                drop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    collecting = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) state_d = COLLECT;
      end
      COLLECT: begin
        if (en) collecting = 1'b1;
        else    state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  sample_tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (collecting),
    .tick (tick)
  );

  assign window    = {shreg, in_bit};
  assign done      = tick && (bcnt == BW'(WIDTH_IN - 1));
  assign slot_free = !out_valid || out_ready;
  assign drop      = done && !slot_free;

  // Leaving COLLECT discards any partial window.
  always_ff @(posedge clk) begin
    if (!rst_n || !collecting) begin
      shreg <= '0;
      bcnt  <= '0;
    end else if (tick) begin
      shreg <= window[WIDTH_IN-2:0];
      bcnt  <= done ? '0 : bcnt + 1'b1;
    end
  end

  // A completing window may replace one being consumed this cycle, so no bubble appears.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_seq   <= '0;
      out_valid <= 1'b0;
    end else if (done && slot_free) begin
      out_seq   <= window;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clr_ovr) begin
      overrun <= 1'b0;
    end
  end

`ifdef OVERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovr_cnt <= '0;
    end else if (drop && (ovr_cnt != {OVR_CNT_W{1'b1}})) begin
      ovr_cnt <= ovr_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_majority_sample_collector.sv
// Scoreboard bench for majority_sample_collector (WIDTH_IN=5, DIV=4); covers OVERRUN_CNT_EN when defined.
module tb_majority_sample_collector;

  localparam int W   = 5;
  localparam int DIV = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         in_bit;
  logic         clr_ovr;
  logic [W-1:0] out_seq;
  logic         out_valid;
  logic         out_ready;
  logic         overrun;
`ifdef OVERRUN_CNT_EN
  logic [7:0]   ovr_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_win;

  majority_sample_collector #(
    .WIDTH_IN(W),
    .DIV     (DIV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .in_bit   (in_bit),
    .clr_ovr  (clr_ovr),
    .out_seq  (out_seq),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overrun  (overrun)
`ifdef OVERRUN_CNT_EN
    ,
    .ovr_cnt  (ovr_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one bit per sample period, oldest first; assumes a period boundary at entry.
  task automatic feed_bits(input logic [W-1:0] bits, input int nbits);
    for (int i = W - 1; i >= W - nbits; i--) begin
      in_bit = bits[i];
      step(DIV);
    end
  endtask

  task automatic pop_expected();
    if (exp_q.size() == 0) begin
      exp_win = 'x;
    end else begin
      exp_win = exp_q.pop_front();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; in_bit = 1'b1; clr_ovr = 1'b0; out_ready = 1'b1;
    step(3);
    checks++; if (out_seq !== 5'b00000) begin errors++; $display("[TB] FAIL reset_out_seq got %b exp %b", out_seq, 5'b00000); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun got %b exp 0", overrun); end
`ifdef OVERRUN_CNT_EN
    checks++; if (ovr_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_ovr_cnt got %0d exp 0", ovr_cnt); end
`endif
    en = 1'b0;
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_basic_window();
    out_ready = 1'b1;
    en = 1'b1;
    step(1);
    exp_q.push_back(5'b10110);
    feed_bits(5'b10110, 4);
    in_bit = 1'b0;
    step(DIV - 1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_early_valid got %b exp 0 at edge 19", out_valid); end
    step(1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid got %b exp 1 at edge 20", out_valid); end
    pop_expected();
    checks++; if (out_seq !== exp_win) begin errors++; $display("[TB] FAIL basic_out_seq got %b exp %b", out_seq, exp_win); end
    step(1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_valid_fall got %b exp 0", out_valid); end
    en = 1'b0;
    step(1);
  endtask

  task automatic test_stall_overrun();
    out_ready = 1'b0;
    en = 1'b1;
    step(1);
    exp_q.push_back(5'b11100);
    feed_bits(5'b11100, W);
    feed_bits(5'b00011, W);
    pop_expected();
    checks++; if (out_seq !== exp_win) begin errors++; $display("[TB] FAIL stall_out_seq got %b exp %b", out_seq, exp_win); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid got %b exp 1", out_valid); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL stall_overrun got %b exp 1", overrun); end
`ifdef OVERRUN_CNT_EN
    checks++; if (ovr_cnt !== 8'd1) begin errors++; $display("[TB] FAIL stall_ovr_cnt got %0d exp 1", ovr_cnt); end
`endif
    en = 1'b0;
    clr_ovr = 1'b1;
    step(1);
    clr_ovr = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL clr_ovr got %b exp 0", overrun); end
`ifdef OVERRUN_CNT_EN
    checks++; if (ovr_cnt !== 8'd1) begin errors++; $display("[TB] FAIL clr_ovr_cnt_hold got %0d exp 1", ovr_cnt); end
`endif
    out_ready = 1'b1;
    step(1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    en = 1'b1;
    step(1);
    exp_q.push_back(5'b01101);
    feed_bits(5'b01101, W);
    pop_expected();
    checks++; if (out_seq !== exp_win) begin errors++; $display("[TB] FAIL b2b_first got %b exp %b", out_seq, exp_win); end
    exp_q.push_back(5'b10010);
    feed_bits(5'b10010, 4);
    in_bit = 1'b0;
    step(DIV - 1);
    out_ready = 1'b1;
    step(1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid got %b exp 1", out_valid); end
    pop_expected();
    checks++; if (out_seq !== exp_win) begin errors++; $display("[TB] FAIL b2b_second got %b exp %b", out_seq, exp_win); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL b2b_overrun got %b exp 0", overrun); end
    en = 1'b0;
    step(1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_valid_fall got %b exp 0", out_valid); end
  endtask

  task automatic test_enable_drop();
    out_ready = 1'b1;
    en = 1'b1;
    step(1);
    in_bit = 1'b1;
    step(3 * DIV);
    en = 1'b0;
    step(1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL endrop_partial got %b exp 0", out_valid); end
    en = 1'b1;
    step(1);
    exp_q.push_back(5'b00000);
    in_bit = 1'b0;
    step(W * DIV - 1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL endrop_early got %b exp 0 at edge 19", out_valid); end
    step(1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL endrop_valid got %b exp 1 at edge 20", out_valid); end
    pop_expected();
    checks++; if (out_seq !== exp_win) begin errors++; $display("[TB] FAIL endrop_out_seq got %b exp %b", out_seq, exp_win); end
    en = 1'b0;
    step(1);
  endtask

  task automatic test_reset_mid_window();
    out_ready = 1'b0;
    en = 1'b1;
    step(1);
    in_bit = 1'b1;
    step(2 * DIV - 1);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    checks++; if (out_seq !== 5'b00000) begin errors++; $display("[TB] FAIL midrst_out_seq got %b exp %b", out_seq, 5'b00000); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid got %b exp 0", out_valid); end
`ifdef OVERRUN_CNT_EN
    checks++; if (ovr_cnt !== 8'd0) begin errors++; $display("[TB] FAIL midrst_ovr_cnt got %0d exp 0", ovr_cnt); end
`endif
    out_ready = 1'b1;
    step(1);
    exp_q.push_back(5'b00101);
    feed_bits(5'b00101, 4);
    in_bit = 1'b1;
    step(DIV - 1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_early got %b exp 0 at edge 19", out_valid); end
    step(1);
    pop_expected();
    checks++; if (out_valid !== 1'b1 || out_seq !== exp_win) begin
      errors++; $display("[TB] FAIL midrst_fresh got valid %b seq %b exp valid 1 seq %b", out_valid, out_seq, exp_win);
    end
    en = 1'b0;
    step(2);
  endtask

`ifdef OVERRUN_CNT_EN
  task automatic test_saturation();
    out_ready = 1'b0;
    en = 1'b1;
    in_bit = 1'b1;
    step(1);
    step(W * DIV * 301);
    checks++; if (ovr_cnt !== 8'd255) begin errors++; $display("[TB] FAIL sat_ovr_cnt got %0d exp 255", ovr_cnt); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL sat_overrun got %b exp 1", overrun); end
    en = 1'b0;
    step(1);
  endtask
`endif

  initial begin
    rst_n = 1'b0; en = 1'b0; in_bit = 1'b0; clr_ovr = 1'b0; out_ready = 1'b0;
    #1;
    test_reset();
    test_basic_window();
    test_stall_overrun();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid_window();
`ifdef OVERRUN_CNT_EN
    test_saturation();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
